alarm_ctrl: RTL and testbench
=============================

ALARM_CTRL -- requirements
Module: alarm_ctrl

Interface
REQ-001 The block SHALL have the parameter RING_SECS, default 60, giving the maximum ring duration in seconds.
REQ-002 The block SHALL have the parameter SNOOZE_SECS, default 540, giving the snooze delay in seconds.
REQ-003 The block SHALL have the parameter BLINK_DIV, default 25_000_000, giving the number of clk cycles per half-period of buzz.
REQ-004 The block SHALL have the port clk, input, width 1: the single system clock; all state SHALL be clocked on its rising edge.
REQ-005 The block SHALL have the port reset_n, input, width 1: asynchronous, active-low reset.
REQ-006 The block SHALL have the port s_tick, input, width 1: a one-clk-cycle pulse at 1 Hz, synchronous to clk.
REQ-007 The block SHALL have the ports hour, min and sec, inputs, widths 5, 6 and 6: the current time of day.
REQ-008 The block SHALL have the ports inc_h and inc_m, inputs, width 1 each: single-cycle pulses that advance the alarm hour and the alarm minute.
REQ-009 The block SHALL have the port arm, input, width 1: a level that enables the alarm while high.
REQ-010 The block SHALL have the port snooze, input, width 1: a single-cycle pulse requesting snooze.
REQ-011 The block SHALL have the port stop, input, width 1: a single-cycle pulse that stops ringing or snooze.
REQ-012 The block SHALL have the ports alarm_h and alarm_m, outputs, widths 5 and 6: the current alarm time, intended for the 7-segment display.
REQ-013 The block SHALL have the port ringing, output, width 1: high while in state RING.
REQ-014 The block SHALL have the port buzz, output, width 1: a square wave while ringing, otherwise 0.
REQ-015 The block SHALL have the port state_o, output, width 2: the state encoding, IDLE=0, ARMED=1, RING=2, SNOOZE=3.

Function
REQ-016 The alarm registers SHALL respond as follows:
- An inc_h pulse SHALL set alarm_h to alarm_h+1, wrapping from 23 to 0.
- An inc_m pulse SHALL set alarm_m to alarm_m+1, wrapping from 59 to 0.
- No carry SHALL pass from minute to hour.
- inc_h and inc_m SHALL be accepted in every state.
REQ-017 match SHALL be defined as (hour==alarm_h && min==alarm_m && sec==0), registered each cycle as match_q; trig SHALL be match && !match_q, i.e. a rising edge only.
REQ-018 The IDLE state SHALL behave as follows:
- It SHALL go to ARMED on the cycle after arm is observed high.
- trig SHALL be ignored.
REQ-019 The ARMED state SHALL behave as follows:
- It SHALL go to IDLE when arm is low.
- Otherwise it SHALL go to RING on trig.
- trig SHALL cause RING one cycle after the cycle in which trig is high.
REQ-020 On entering RING, the block SHALL clear the second counter sec_cnt to 0; sec_cnt SHALL then increment on each s_tick.
REQ-021 RING SHALL exit with the following priority:
- On arm low or stop, it SHALL go to ARMED if arm is high, otherwise to IDLE.
- Otherwise, on snooze, it SHALL go to SNOOZE.
- Otherwise, when sec_cnt reaches RING_SECS on an s_tick, it SHALL go to ARMED.
REQ-022 On entering SNOOZE, the block SHALL clear sec_cnt.
REQ-023 SNOOZE SHALL exit with the following priority:
- On arm low or stop, it SHALL go to ARMED if arm is high, otherwise to IDLE.
- Otherwise, when sec_cnt reaches SNOOZE_SECS on an s_tick, it SHALL go to RING.
- snooze pulses SHALL be ignored.
REQ-024 sec_cnt SHALL be 10 bits wide; it SHALL saturate and never wrap while the block is in RING or SNOOZE.
REQ-025 A trig that occurs while the block is in RING or SNOOZE SHALL be ignored, so that the alarm does not retrigger.
REQ-026 buzz SHALL be generated as follows:
- A cycle counter SHALL count up to BLINK_DIV-1 and then toggle buzz.
- The counter SHALL reset to 0 and buzz SHALL be set to 1 on entry to RING.
- buzz SHALL be forced to 0 and the counter held at 0 in every state other than RING.
REQ-027 Simultaneous events SHALL be resolved as follows:
- stop together with snooze: stop SHALL win.
- inc_m in the same cycle as trig: the trig computed from the pre-increment alarm_m SHALL stand.
- s_tick in the same cycle as a state entry: sec_cnt SHALL be cleared and SHALL NOT also increment.
REQ-028 ringing SHALL equal (state==RING), and all outputs SHALL be driven directly from registers.

Reset
REQ-029 While reset_n is low, the block SHALL asynchronously set state=IDLE, alarm_h=6, alarm_m=0, sec_cnt=0, the blink counter to 0, buzz=0, ringing=0 and match_q=1.
REQ-030 Because match_q resets to 1, no trig SHALL fire in the first cycle after reset even when the time already matches.
REQ-031 If reset_n is asserted mid-RING, the block SHALL drop ringing and buzz to 0 in the same cycle, without waiting for a clock edge.

Verification
REQ-032 Scenario: arm=1, alarm 06:00, time steps 05:59:59 -> 06:00:00 -> ringing=1 one cycle after the match, buzz=1 and toggling every BLINK_DIV cycles.
REQ-033 Scenario: ringing, no input, 60 s_ticks -> state ARMED, buzz=0; time held at 06:00:00 does not retrigger.
REQ-034 Scenario: ringing, snooze pulse -> SNOOZE; after 540 s_ticks -> RING again; stop during the second RING -> ARMED.
REQ-035 Scenario: alarm_m=59, inc_m -> 0 with alarm_h unchanged; alarm_h=23, inc_h -> 0.
REQ-036 Scenario: arm dropped during SNOOZE -> IDLE the next cycle; stop+snooze in the same cycle during RING -> ARMED.
REQ-037 Scenario: reset_n low mid-RING -> outputs reset immediately; release with time at 06:00:00 -> no ring.

Source files
------------

// File: rtl/alarm_ctrl.sv
// Alarm-clock controller: alarm time registers, IDLE/ARMED/RING/SNOOZE sequencing and buzzer square wave.
// One-cycle trig-to-RING latency; no backpressure, every input pulse is acted on in the cycle it arrives.
module alarm_ctrl #(
  parameter int RING_SECS   = 60,
  parameter int SNOOZE_SECS = 540,
  parameter int BLINK_DIV   = 25_000_000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       s_tick,
  input  logic [4:0] hour,
  input  logic [5:0] min,
  input  logic [5:0] sec,
  input  logic       inc_h,
  input  logic       inc_m,
  input  logic       arm,
  input  logic       snooze,
  input  logic       stop,
  output logic [4:0] alarm_h,
  output logic [5:0] alarm_m,
  output logic       ringing,
  output logic       buzz,
  output logic [1:0] state_o
);

  localparam int               BW          = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BW-1:0]    BLINK_LAST  = BW'(BLINK_DIV - 1);
  localparam logic [10:0]      RING_LIM    = 11'(RING_SECS);
  localparam logic [10:0]      SNOOZE_LIM  = 11'(SNOOZE_SECS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    RING   = 2'd2,
    SNOOZE = 2'd3
  } state_t;

  state_t        state_q;
  logic [4:0]    alarm_h_q, alarm_h_d;
  logic [5:0]    alarm_m_q, alarm_m_d;
  logic          match_q;
  logic [9:0]    sec_cnt_q;
  logic [9:0]    sec_cnt_sat;
  logic [10:0]   sec_inc;
  logic [BW-1:0] blink_cnt_q;
  logic          buzz_q;
  logic          ringing_q;
  logic          match;
  logic          trig;
  logic          ring_done;
  logic          snooze_done;

  // match uses the alarm registers before any same-cycle increment lands
  assign match       = (hour == alarm_h_q) && (min == alarm_m_q) && (sec == 6'd0);
  assign trig        = match && !match_q;
  assign sec_inc     = {1'b0, sec_cnt_q} + 11'd1;
  assign sec_cnt_sat = (sec_cnt_q == 10'h3FF) ? sec_cnt_q : sec_inc[9:0];
  assign ring_done   = s_tick && (sec_inc >= RING_LIM);
  assign snooze_done = s_tick && (sec_inc >= SNOOZE_LIM);

  assign alarm_h_d = (alarm_h_q == 5'd23) ? 5'd0 : alarm_h_q + 5'd1;
  assign alarm_m_d = (alarm_m_q == 6'd59) ? 6'd0 : alarm_m_q + 6'd1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      alarm_h_q <= 5'd6;
      alarm_m_q <= 6'd0;
      match_q   <= 1'b1;
    end else begin
      match_q <= match;
      if (inc_h) alarm_h_q <= alarm_h_d;
      if (inc_m) alarm_m_q <= alarm_m_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      sec_cnt_q   <= 10'd0;
      blink_cnt_q <= '0;
      buzz_q      <= 1'b0;
      ringing_q   <= 1'b0;
    end else begin
      sec_cnt_q   <= 10'd0;
      blink_cnt_q <= '0;
      buzz_q      <= 1'b0;
      ringing_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (arm) state_q <= ARMED;
        end
        ARMED: begin
          if (!arm) begin
            state_q <= IDLE;
          end else if (trig) begin
            state_q   <= RING;
            ringing_q <= 1'b1;
            buzz_q    <= 1'b1;
          end
        end
        RING: begin
          if (!arm || stop) begin
            state_q <= arm ? ARMED : IDLE;
          end else if (snooze) begin
            state_q <= SNOOZE;
          end else if (ring_done) begin
            state_q <= ARMED;
          end else begin
            ringing_q <= 1'b1;
            sec_cnt_q <= s_tick ? sec_cnt_sat : sec_cnt_q;
            if (blink_cnt_q == BLINK_LAST) begin
              blink_cnt_q <= '0;
              buzz_q      <= ~buzz_q;
            end else begin
              blink_cnt_q <= blink_cnt_q + 1'b1;
              buzz_q      <= buzz_q;
            end
          end
        end
        SNOOZE: begin
          if (!arm || stop) begin
            state_q <= arm ? ARMED : IDLE;
          end else if (snooze_done) begin
            state_q   <= RING;
            ringing_q <= 1'b1;
            buzz_q    <= 1'b1;
          end else begin
            sec_cnt_q <= s_tick ? sec_cnt_sat : sec_cnt_q;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign alarm_h = alarm_h_q;
  assign alarm_m = alarm_m_q;
  assign ringing = ringing_q;
  assign buzz    = buzz_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Bench for alarm_ctrl: directed scenarios plus random stimulus against a behavioural model.
module tb_alarm_ctrl;
  localparam int RING_SECS   = 60;
  localparam int SNOOZE_SECS = 540;
  localparam int BLINK_DIV   = 4;
  localparam int M_IDLE = 0, M_ARMED = 1, M_RING = 2, M_SNOOZE = 3;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       s_tick = 1'b0;
  logic [4:0] hour = 5'd0;
  logic [5:0] min = 6'd0;
  logic [5:0] sec = 6'd0;
  logic       inc_h = 1'b0, inc_m = 1'b0, arm = 1'b0, snooze = 1'b0, stop = 1'b0;
  logic [4:0] alarm_h;
  logic [5:0] alarm_m;
  logic       ringing, buzz;
  logic [1:0] state_o;

  int checks = 0;
  int failures = 0;

  alarm_ctrl #(.RING_SECS(RING_SECS), .SNOOZE_SECS(SNOOZE_SECS), .BLINK_DIV(BLINK_DIV)) dut (
    .clk(clk), .reset_n(reset_n), .s_tick(s_tick), .hour(hour), .min(min), .sec(sec),
    .inc_h(inc_h), .inc_m(inc_m), .arm(arm), .snooze(snooze), .stop(stop),
    .alarm_h(alarm_h), .alarm_m(alarm_m), .ringing(ringing), .buzz(buzz), .state_o(state_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: alarm time as integers, time-in-state as plain counts.
  int m_state, m_ah, m_am, m_secs, m_rcyc;
  bit m_prev, m_buzz;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_state = M_IDLE; m_ah = 6; m_am = 0; m_prev = 1'b1;
      m_secs = 0; m_rcyc = 0; m_buzz = 1'b0;
    end else begin
      bit match, trig;
      int nxt;
      match  = (hour == m_ah) && (min == m_am) && (sec == 0);
      trig   = match && !m_prev;
      m_prev = match;
      nxt    = m_state;
      case (m_state)
        M_IDLE:   if (arm) nxt = M_ARMED;
        M_ARMED:  if (!arm) nxt = M_IDLE; else if (trig) nxt = M_RING;
        M_RING: begin
          if (!arm || stop) nxt = arm ? M_ARMED : M_IDLE;
          else if (snooze) nxt = M_SNOOZE;
          else if (s_tick && m_secs + 1 >= RING_SECS) nxt = M_ARMED;
        end
        default: begin
          if (!arm || stop) nxt = arm ? M_ARMED : M_IDLE;
          else if (s_tick && m_secs + 1 >= SNOOZE_SECS) nxt = M_RING;
        end
      endcase
      if (nxt != m_state && nxt >= M_RING) m_secs = 0;
      else if (m_state >= M_RING && s_tick && m_secs < 1023) m_secs = m_secs + 1;
      if (nxt == M_RING) m_rcyc = (m_state == M_RING) ? m_rcyc + 1 : 0;
      m_buzz  = (nxt == M_RING) && (((m_rcyc / BLINK_DIV) % 2) == 0);
      m_state = nxt;
      if (inc_h) m_ah = (m_ah + 1) % 24;
      if (inc_m) m_am = (m_am + 1) % 60;
    end
  end

  always @(negedge clk) begin
    check_eq("state", state_o, m_state);
    check_eq("ringing", ringing, (m_state == M_RING));
    check_eq("buzz", buzz, m_buzz);
    check_eq("alarm_h", alarm_h, m_ah);
    check_eq("alarm_m", alarm_m, m_am);
  end

  task automatic cycle();
    @(negedge clk);
    s_tick = 1'b0; snooze = 1'b0; stop = 1'b0; inc_h = 1'b0; inc_m = 1'b0;
  endtask

  task automatic tick_n(input int n);
    repeat (n) begin
      s_tick = 1'b1; cycle();
      cycle();
    end
  endtask

  task automatic ring_up();
    hour = 5'(m_ah); min = 6'(m_am); sec = 6'd1; cycle();
    sec = 6'd0; cycle();
    check_eq("ring_up", ringing, 1'b1);
  endtask

  initial begin
    hour = 5'd6; min = 6'd0; sec = 6'd0; arm = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst_state", state_o, 0);
    check_eq("rst_alarm_h", alarm_h, 6);
    check_eq("rst_alarm_m", alarm_m, 0);
    check_eq("rst_buzz", buzz, 0);
    reset_n = 1'b1;
    repeat (5) cycle();
    check_eq("no_ring_after_rst", state_o, M_ARMED);

    // Ring on rising match edge, buzz toggles every BLINK_DIV cycles
    hour = 5'd5; min = 6'd59; sec = 6'd59; cycle();
    hour = 5'd6; min = 6'd0; sec = 6'd0; cycle();
    check_eq("ring_entry", ringing, 1'b1);
    check_eq("buzz_entry", buzz, 1'b1);
    repeat (BLINK_DIV - 1) cycle();
    check_eq("buzz_hold", buzz, 1'b1);
    cycle();
    check_eq("buzz_toggle", buzz, 1'b0);
    repeat (BLINK_DIV) cycle();
    check_eq("buzz_toggle2", buzz, 1'b1);

    // Ring timeout, held match does not retrigger
    tick_n(RING_SECS - 1);
    check_eq("ring_before_timeout", state_o, M_RING);
    tick_n(1);
    check_eq("ring_timeout", state_o, M_ARMED);
    check_eq("buzz_off", buzz, 1'b0);
    repeat (10) cycle();
    check_eq("no_retrigger", state_o, M_ARMED);

    // Snooze then re-ring, stop
    ring_up();
    snooze = 1'b1; cycle();
    check_eq("snooze_entry", state_o, M_SNOOZE);
    tick_n(SNOOZE_SECS - 1);
    check_eq("snooze_hold", state_o, M_SNOOZE);
    tick_n(1);
    check_eq("snooze_rering", state_o, M_RING);
    stop = 1'b1; cycle();
    check_eq("stop_ring", state_o, M_ARMED);

    // Arm dropped in SNOOZE; stop beats snooze
    ring_up();
    snooze = 1'b1; cycle();
    arm = 1'b0; cycle();
    check_eq("disarm_snooze", state_o, M_IDLE);
    arm = 1'b1; cycle();
    ring_up();
    stop = 1'b1; snooze = 1'b1; cycle();
    check_eq("stop_wins", state_o, M_ARMED);

    // Asynchronous reset mid-ring
    ring_up();
    #2 reset_n = 1'b0;
    #1;
    check_eq("arst_ringing", ringing, 1'b0);
    check_eq("arst_buzz", buzz, 1'b0);
    check_eq("arst_state", state_o, M_IDLE);
    hour = 5'd6; min = 6'd0; sec = 6'd0; arm = 1'b1;
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    repeat (8) cycle();
    check_eq("arst_no_ring", state_o, M_ARMED);

    // Alarm register wrap
    hour = 5'd12;
    repeat (59) begin inc_m = 1'b1; cycle(); end
    check_eq("alarm_m_59", alarm_m, 59);
    inc_m = 1'b1; cycle();
    check_eq("alarm_m_wrap", alarm_m, 0);
    check_eq("no_carry", alarm_h, 6);
    repeat (17) begin inc_h = 1'b1; cycle(); end
    check_eq("alarm_h_23", alarm_h, 23);
    inc_h = 1'b1; cycle();
    check_eq("alarm_h_wrap", alarm_h, 0);

    // Random traffic against the model
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 199) == 0) arm = ~arm;
      s_tick = ($urandom_range(0, 2) == 0);
      snooze = ($urandom_range(0, 149) == 0);
      stop   = ($urandom_range(0, 299) == 0);
      inc_h  = ($urandom_range(0, 199) == 0);
      inc_m  = ($urandom_range(0, 199) == 0);
      case ($urandom_range(0, 19))
        0: begin hour = 5'(m_ah); min = 6'(m_am); sec = 6'd0; end
        1: begin hour = 5'(m_ah); min = 6'(m_am); sec = 6'd1; end
        2: begin
          hour = 5'($urandom_range(0, 23));
          min  = 6'($urandom_range(0, 59));
          sec  = 6'($urandom_range(0, 59));
        end
        default: ;
      endcase
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
